// File: rtl/loader_pkg.sv
// Shared types and sizing for the image/palette byte-stream loader.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PAL_HI = 2'd1,
        PAL_LO = 2'd2,
        IMG    = 2'd3
    } loader_state_t;

    localparam int DEF_WIDTH     = 256;
    localparam int DEF_HEIGHT    = 256;
    localparam int DEF_PAL_DEPTH = 256;
    localparam int PAL_AW        = 8;

    // Never narrower than one bit, so a 1x1 image still gets a legal address port.
    function automatic int img_aw(input int w, input int h);
        return (w * h > 1) ? $clog2(w * h) : 1;
    endfunction

    localparam int IMG_AW = img_aw(DEF_WIDTH, DEF_HEIGHT);

endpackage

// File: rtl/image_loader_if.sv
// Byte-stream handshake plus the palette/image RAM write-port bundle.
interface image_loader_if
    import loader_pkg::*;
#(
    parameter int IMG_AW = loader_pkg::IMG_AW
);
    logic              start_in;
    logic              abort_in;
    logic [7:0]        data_in;
    logic              valid_in;
    logic              ready_out;
    logic [PAL_AW-1:0] pal_addr_out;
    logic [11:0]       pal_data_out;
    logic              pal_we_out;
    logic [IMG_AW-1:0] img_addr_out;
    logic [7:0]        img_data_out;
    logic              img_we_out;
    logic              busy_out;
    logic              done_out;

    modport master (
        output start_in, abort_in, data_in, valid_in,
        input  ready_out, pal_addr_out, pal_data_out, pal_we_out,
               img_addr_out, img_data_out, img_we_out, busy_out, done_out
    );

    modport slave (
        input  start_in, abort_in, data_in, valid_in,
        output ready_out, pal_addr_out, pal_data_out, pal_we_out,
               img_addr_out, img_data_out, img_we_out, busy_out, done_out
    );
endinterface

// File: rtl/image_loader.sv
// Fills the palette RAM (12-bit {R,G,B}) then the image RAM (8-bit indices) from a byte stream.
module image_loader
    import loader_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int HEIGHT    = DEF_HEIGHT,
    parameter int PAL_DEPTH = DEF_PAL_DEPTH
) (
    input  logic           pixel_clk_in,
    input  logic           rst_in,
    image_loader_if.slave  bus
);
    localparam int IMG_AW = img_aw(WIDTH, HEIGHT);
    localparam logic [PAL_AW-1:0] PAL_LAST = PAL_AW'(PAL_DEPTH - 1);
    localparam logic [IMG_AW-1:0] IMG_LAST = IMG_AW'(WIDTH * HEIGHT - 1);

    loader_state_t     r_state;
    logic [3:0]        r_red;
    logic [PAL_AW-1:0] r_pal_cnt;
    logic [IMG_AW-1:0] r_pix_cnt;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_pal_we;
    logic [PAL_AW-1:0] r_pal_addr;
    logic [11:0]       r_pal_data;
    logic              r_img_we;
    logic [IMG_AW-1:0] r_img_addr;
    logic [7:0]        r_img_data;

    logic w_xfer;
    assign w_xfer = bus.valid_in && r_ready;

    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            r_state    <= IDLE;
            r_red      <= '0;
            r_pal_cnt  <= '0;
            r_pix_cnt  <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pal_we   <= 1'b0;
            r_pal_addr <= '0;
            r_pal_data <= '0;
            r_img_we   <= 1'b0;
            r_img_addr <= '0;
            r_img_data <= '0;
        end else begin
            r_pal_we <= 1'b0;
            r_img_we <= 1'b0;
            r_done   <= 1'b0;
            // Abort wins over any coincident transfer in every busy state.
            if (r_state != IDLE && bus.abort_in) begin
                r_state <= IDLE;
                r_ready <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start_in) begin
                            r_state   <= PAL_HI;
                            r_ready   <= 1'b1;
                            r_busy    <= 1'b1;
                            r_pal_cnt <= '0;
                            r_pix_cnt <= '0;
                        end
                    end
                    PAL_HI: begin
                        if (w_xfer) begin
                            r_red   <= bus.data_in[3:0];
                            r_state <= PAL_LO;
                        end
                    end
                    PAL_LO: begin
                        if (w_xfer) begin
                            r_pal_we   <= 1'b1;
                            r_pal_addr <= r_pal_cnt;
                            r_pal_data <= {r_red, bus.data_in};
                            if (r_pal_cnt == PAL_LAST) begin
                                r_state <= IMG;
                            end else begin
                                r_pal_cnt <= r_pal_cnt + 1'b1;
                                r_state   <= PAL_HI;
                            end
                        end
                    end
                    IMG: begin
                        if (w_xfer) begin
                            r_img_we   <= 1'b1;
                            r_img_addr <= r_pix_cnt;
                            r_img_data <= bus.data_in;
                            if (r_pix_cnt == IMG_LAST) begin
                                r_state <= IDLE;
                                r_ready <= 1'b0;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_pix_cnt <= r_pix_cnt + 1'b1;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.ready_out    = r_ready;
    assign bus.busy_out     = r_busy;
    assign bus.done_out     = r_done;
    assign bus.pal_we_out   = r_pal_we;
    assign bus.pal_addr_out = r_pal_addr;
    assign bus.pal_data_out = r_pal_data;
    assign bus.img_we_out   = r_img_we;
    assign bus.img_addr_out = r_img_addr;
    assign bus.img_data_out = r_img_data;

endmodule

// File: tb/tb_image_loader.sv
// Directed/random bench for image_loader against a stream-level model of the expected RAM writes.
module tb_image_loader;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int P    = 2;
    localparam int NPIX = W * H;
    localparam int NB   = 2 * P + NPIX;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    image_loader_if #(.IMG_AW(3)) bus();

    image_loader #(.WIDTH(W), .HEIGHT(H), .PAL_DEPTH(P)) dut (
        .pixel_clk_in (clk),
        .rst_in       (rst_n),
        .bus          (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  stream_b [$];
    logic [19:0] q_pal [$];
    logic [10:0] q_img [$];
    int done_cnt = 0;
    int done_last = 0;

    always @(negedge clk) begin
        if (bus.pal_we_out === 1'b1) q_pal.push_back({bus.pal_addr_out, bus.pal_data_out});
        if (bus.img_we_out === 1'b1) q_img.push_back({bus.img_addr_out, bus.img_data_out});
        if (bus.done_out === 1'b1) begin
            done_cnt++;
            if (bus.img_we_out === 1'b1 && bus.img_addr_out === 3'd7) done_last++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        @(posedge clk);
        q_pal.delete();
        q_img.delete();
        done_cnt = 0;
        done_last = 0;
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
    endtask

    // Feeds stream_b[0..n-1]; optional abort/start pulses ride along with a chosen accepted byte.
    task automatic run_stream(input int n, input bit rnd, input int abort_at, input int start_at);
        int i = 0;
        int guard = 0;
        bit v;
        while (i < n) begin
            @(negedge clk);
            bus.start_in = 1'b0;
            bus.abort_in = 1'b0;
            v = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.valid_in = v;
            bus.data_in  = v ? stream_b[i] : 8'($urandom);
            if (v && bus.ready_out === 1'b1) begin
                if (i == abort_at) bus.abort_in = 1'b1;
                if (i == start_at) bus.start_in = 1'b1;
                i++;
                if (i - 1 == abort_at) break;
            end
            guard++;
            if (guard > 2000) begin
                chk("stream_timeout", 64'(i), 64'(n));
                break;
            end
        end
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.abort_in = 1'b0;
        bus.start_in = 1'b0;
    endtask

    task automatic rand_stream();
        stream_b.delete();
        for (int i = 0; i < NB; i++) stream_b.push_back(8'($urandom));
    endtask

    // Expected writes come straight from the stream layout: byte pairs then raster indices.
    task automatic check_load(input string tag);
        repeat (3) @(negedge clk);
        chk({tag, "_pal_n"}, 64'(q_pal.size()), 64'(P));
        for (int e = 0; e < P && e < q_pal.size(); e++)
            chk({tag, "_pal"}, 64'(q_pal[e]),
                64'({8'(e), stream_b[2*e][3:0], stream_b[2*e+1]}));
        chk({tag, "_img_n"}, 64'(q_img.size()), 64'(NPIX));
        for (int n = 0; n < NPIX && n < q_img.size(); n++)
            chk({tag, "_img"}, 64'(q_img[n]), 64'({3'(n), stream_b[2*P+n]}));
        chk({tag, "_done_n"}, 64'(done_cnt), 64'd1);
        chk({tag, "_done_last"}, 64'(done_last), 64'd1);
        chk({tag, "_busy"}, 64'(bus.busy_out), 64'd0);
        chk({tag, "_ready"}, 64'(bus.ready_out), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.start_in = 1'b1;
        bus.abort_in = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in  = 8'h5A;

        // 1: reset holds every output low even with start/valid asserted
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("reset_outs", 64'({bus.ready_out, bus.pal_addr_out, bus.pal_data_out, bus.pal_we_out,
                                   bus.img_addr_out, bus.img_data_out, bus.img_we_out,
                                   bus.busy_out, bus.done_out}), 64'd0);
        end
        bus.start_in = 1'b0;
        bus.valid_in = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // 2: directed full load, continuous valid
        stream_b = '{8'h0F, 8'hAB, 8'h03, 8'hCD, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        clear_log();
        do_start();
        chk("start_busy", 64'(bus.busy_out), 64'd1);
        chk("start_ready", 64'(bus.ready_out), 64'd1);
        run_stream(NB, 1'b0, -1, -1);
        check_load("full");

        // 3: random bytes with random stalls
        for (int r = 0; r < 3; r++) begin
            rand_stream();
            clear_log();
            do_start();
            run_stream(NB, 1'b1, -1, -1);
            check_load("stall");
        end

        // 4: abort coincident with pixel 3
        rand_stream();
        clear_log();
        do_start();
        run_stream(NB, 1'b1, 2*P + 3, -1);
        chk("abort_busy", 64'(bus.busy_out), 64'd0);
        chk("abort_img_we", 64'(bus.img_we_out), 64'd0);
        chk("abort_ready", 64'(bus.ready_out), 64'd0);
        repeat (2) @(negedge clk);
        chk("abort_img_n", 64'(q_img.size()), 64'd3);
        chk("abort_pal_n", 64'(q_pal.size()), 64'(P));
        chk("abort_done", 64'(done_cnt), 64'd0);
        rand_stream();
        clear_log();
        do_start();
        run_stream(NB, 1'b1, -1, -1);
        check_load("reload");

        // 5: start during IMG is ignored
        rand_stream();
        clear_log();
        do_start();
        run_stream(NB, 1'b1, -1, 2*P + 2);
        check_load("start_in_img");

        // 6: reset while in PAL_LO drops the pending entry
        rand_stream();
        clear_log();
        do_start();
        run_stream(3, 1'b1, -1, -1);
        rst_n = 1'b0;
        bus.valid_in = 1'b1;
        bus.data_in = 8'($urandom);
        @(negedge clk);
        chk("rst_mid_pal_we", 64'(bus.pal_we_out), 64'd0);
        chk("rst_mid_outs", 64'({bus.ready_out, bus.busy_out, bus.done_out, bus.img_we_out}), 64'd0);
        rst_n = 1'b1;
        bus.valid_in = 1'b0;
        @(negedge clk);
        chk("rst_mid_pal_n", 64'(q_pal.size()), 64'd1);
        chk("rst_mid_idle", 64'({bus.busy_out, bus.ready_out}), 64'd0);
        do_start();
        chk("rst_restart_ready", 64'(bus.ready_out), 64'd1);
        @(negedge clk);
        bus.abort_in = 1'b1;
        @(negedge clk);
        bus.abort_in = 1'b0;
        chk("final_abort_busy", 64'(bus.busy_out), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
